fifo_umbral: RTL and testbench
==============================

# fifo_umbral

Parameterised synchronous FIFO with programmable almost-full/almost-empty thresholds and sticky overflow/underflow error. It is the buffer instance used for the Main FIFO, the VC FIFOs and the D FIFOs around the flow-control FSM. It consumes the FSM's threshold outputs (`afMF_o`/`aeMF_o`, `afVC_o`/`aeVC_o`, `afD_o`/`aeD_o`). It produces the per-FIFO `FIFO_errors`, `FIFO_empties`, almost-full and almost-empty bits that the FSM samples.

## Interface
- `DATA_WIDTH`, default 6: word width.
- `ADDR_WIDTH`, default 2: pointer width.
  - Depth is `DEPTH = 2**ADDR_WIDTH` (default 4).
  - Thresholds are `ADDR_WIDTH` bits wide.
- `clk`  in  1: single clock; everything updates on the rising edge.
- `reset_L`  in  1: asynchronous, active-low reset.
- `push`  in  1: write request for `data_in` this cycle.
- `data_in`  in  DATA_WIDTH: write data.
- `pop`  in  1: read request this cycle.
- `af_th`  in  ADDR_WIDTH: almost-full threshold. Value 0 disables `almost_full`.
- `ae_th`  in  ADDR_WIDTH: almost-empty threshold.
- `data_out`  out  DATA_WIDTH: registered read data.
- `valid_out`  out  1: `data_out` holds a freshly popped word this cycle.
- `full`, `empty`  out  1: occupancy flags.
- `almost_full`, `almost_empty`  out  1: threshold flags.
- `error`  out  1: sticky overflow/underflow indicator.
- `count`  out  ADDR_WIDTH+1: current occupancy, 0..DEPTH.

## Operation
- **Storage:** `DEPTH` x `DATA_WIDTH` register array, plus write pointer `wr_ptr`, read pointer `rd_ptr` (`ADDR_WIDTH` bits each) and `count`.
- **Pointer wrap:** both pointers wrap modulo `DEPTH`, i.e. `DEPTH-1` → 0.
- **Flag definitions** (combinational from `count` and the live threshold inputs; thresholds are not latched):
  - `empty = (count == 0)`
  - `full = (count == DEPTH)`
  - `almost_full = (af_th != 0) && (count >= af_th)`
  - `almost_empty = (count <= ae_th)`
- **Successful push:** `push && (!full || pop)`.
  - Writes `data_in` at `wr_ptr` and increments `wr_ptr`.
- **Successful pop:** `pop && !empty`.
  - Loads `mem[rd_ptr]` into `data_out`, increments `rd_ptr`, asserts `valid_out` for the next cycle.
- **Count update:** `count` changes by (+1 for a successful push) (−1 for a successful pop).
- **Simultaneous push and pop:**
  - When full: both succeed, `count` stays at `DEPTH`, no error.
  - When empty: push succeeds, pop is an underflow. `error` is set, no read occurs, `valid_out` = 0, and `count` goes to 1.
  - Otherwise: both succeed and `count` is unchanged.
- **Overflow:** `push && full && !pop`. Write is dropped, memory and pointers are unchanged, `error` is set.
- **Underflow:** `pop && empty`. Read is dropped, `data_out` holds its value, `error` is set.
- **Error clearing:** `error` clears only on reset. It stays 1 even after the FIFO returns to legal operation.
- **Hold behaviour:**
  - `data_out` holds its last value when no successful pop occurs.
  - `valid_out` is 0 in any cycle not following a successful pop.
- **Reset** (`reset_L` = 0, asynchronous, in any cycle including mid-transfer):
  - `wr_ptr`, `rd_ptr`, `count` = 0; `data_out` = 0; `valid_out` = 0; `error` = 0.
  - Consequently `empty` = 1, `full` = 0, `almost_full` = 0, `almost_empty` = 1.
  - Memory contents are don't-care.
  - Requests in the cycle `reset_L` rises are honoured normally.

## Timing
- **Push latency:** a word pushed at edge N is poppable at edge N+1. There is no fall-through, and no same-cycle read of a word written to an empty FIFO.
- **Pop latency:** pop sampled at edge N presents `data_out`/`valid_out` after edge N. Latency is 1 cycle; the result is valid during cycle N+1.
- **Flag timing:** `count`, `full` and `empty` reflect edge N's operations immediately after edge N.
- **Threshold timing:** `almost_full`/`almost_empty` also respond combinationally, within the same cycle, to changes on `af_th`/`ae_th`.
- **Error timing:** `error` rises right after the edge that samples the illegal request.
- **Throughput:** one push and one pop per cycle, sustained.

## Test plan
- **Reset values:** reset with `af_th`=3, `ae_th`=1 → `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `error`=0, `count`=0, `data_out`=0, `valid_out`=0.
- **Fill, threshold flags, overflow:** push 0x01,0x02,0x03,0x04 on consecutive cycles (`af_th`=3).
  - `almost_full` rises when `count`=3; `full` rises when `count`=4.
  - A 5th push of 0x3F leaves `count`=4 and sets `error`=1.
  - Subsequent pops return 0x01..0x04 in order, with `valid_out` = 1 one cycle after each pop.
- **Underflow:** pop on an empty FIFO → `error`=1, `data_out` unchanged, `valid_out`=0, `count`=0. `error` stays 1 through later legal traffic.
- **Simultaneous push/pop while full:** with the FIFO full, hold `push` and `pop` together for 6 cycles.
  - `count` stays at 4 and `error` stays 0.
  - Output words follow push order across the pointer wrap.
- **Simultaneous push/pop while empty:** → `count`=1, `error`=1, `valid_out`=0. The next pop returns the pushed word.
- **Asynchronous reset mid-operation:** assert `reset_L`=0 mid-cycle with `count`=2 → all outputs return to reset values without waiting for a clock edge. A push in the cycle `reset_L` rises lands at address 0.

Source files
------------

// File: rtl/fifo_umbral.sv
// Purpose : synchronous FIFO with live almost-full/almost-empty thresholds and a sticky error flag.
// Latency : a push is poppable one edge later; pop data/valid_out are registered, valid the cycle after the pop.
// Backpr. : no stall path; overflow drops the write, underflow drops the read, and both set the sticky error.
//
// Ports:
//   clk, reset_L            clock, asynchronous active-low reset
//   push, data_in           write request and write data
//   pop                     read request
//   af_th, ae_th            almost-full (0 disables) / almost-empty thresholds, not latched
//   data_out, valid_out     registered read word, strobe for one cycle after a successful pop
//   full, empty             occupancy flags
//   almost_full/_empty      threshold flags
//   error                   sticky overflow/underflow, cleared only by reset
//   count                   occupancy 0..DEPTH
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] af_th,
    input  logic [ADDR_WIDTH-1:0] ae_th,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int                DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH-1:0] rdPtr;
    logic                  pushOk;
    logic                  popOk;
    logic                  badReq;

    // Flags are purely combinational so threshold changes show up in the same cycle.
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_CNT);
    assign almost_full  = (af_th != '0) && (count >= {1'b0, af_th});
    assign almost_empty = (count <= {1'b0, ae_th});

    // A push into a full FIFO still succeeds when a pop frees the slot in the same edge;
    // the read sees the old word because the array write is non-blocking.
    assign pushOk = push && (!full || pop);
    assign popOk  = pop && !empty;
    assign badReq = (push && full && !pop) || (pop && empty);

    // Storage carries no reset: contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            valid_out <= popOk;
            if (pushOk) begin
                wrPtr <= wrPtr + 1'b1;   // wraps naturally at DEPTH
            end
            if (popOk) begin
                data_out <= mem[rdPtr];
                rdPtr    <= rdPtr + 1'b1;
            end
            case ({pushOk, popOk})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (badReq) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_umbral.sv
module tb_fifo_umbral;

    localparam int DW    = 6;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset_L;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [AW-1:0] af_th;
    logic [AW-1:0] ae_th;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          error;
    logic [AW:0]   count;

    fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .af_th        (af_th),
        .ae_th        (ae_th),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    bit monOn      = 1'b0;

    // Reference model: a plain queue of stored words plus the sticky error and last read word.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] expQ[$];
    bit            mErr    = 1'b0;
    logic [DW-1:0] lastOut = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        expQ.delete();
        mErr    = 1'b0;
        lastOut = '0;
    endtask

    // One clock of stimulus: drive at the falling edge and advance the model to the
    // state the DUT must show after the following rising edge.
    task automatic doCycle(input bit p, input bit q, input logic [DW-1:0] d);
        bit mFull, mEmpty, pOk, qOk;
        @(negedge clk);
        reset_L = 1'b1;
        push    = p;
        pop     = q;
        data_in = d;
        mFull  = (mq.size() == DEPTH);
        mEmpty = (mq.size() == 0);
        pOk    = p && (!mFull || q);
        qOk    = q && !mEmpty;
        if (qOk) begin
            lastOut = mq.pop_front();
            expQ.push_back(lastOut);
        end
        if (pOk) mq.push_back(d);
        if ((p && mFull && !q) || (q && mEmpty)) mErr = 1'b1;
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, " count"},        32'(count),        32'd0);
        chk({tag, " empty"},        32'(empty),        32'd1);
        chk({tag, " full"},         32'(full),         32'd0);
        chk({tag, " almost_full"},  32'(almost_full),  32'd0);
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
        chk({tag, " error"},        32'(error),        32'd0);
        chk({tag, " data_out"},     32'(data_out),     32'd0);
        chk({tag, " valid_out"},    32'(valid_out),    32'd0);
    endtask

    // Called right after an idle doCycle: reset is asserted mid-cycle, before any edge.
    task automatic asyncReset();
        #2;
        reset_L = 1'b0;
        #1;
        checkResetOutputs("async reset");
        modelReset();
        @(posedge clk);
    endtask

    // Monitor: samples shortly after each rising edge and pops the scoreboard on valid_out.
    always @(posedge clk) begin
        #2;
        if (monOn) begin
            int  n;
            bit  expV;
            logic [DW-1:0] w;
            n = mq.size();
            chk("count", 32'(count), 32'(n));
            chk("full",  32'(full),  32'(n == DEPTH));
            chk("empty", 32'(empty), 32'(n == 0));
            chk("almost_full",  32'(almost_full),  32'((af_th != 0) && (n >= int'(af_th))));
            chk("almost_empty", 32'(almost_empty), 32'(n <= int'(ae_th)));
            chk("error", 32'(error), 32'(mErr));
            chk("data_out hold", 32'(data_out), 32'(lastOut));
            expV = (expQ.size() != 0);
            chk("valid_out", 32'(valid_out), 32'(expV));
            if (expV) begin
                w = expQ.pop_front();
                if (valid_out) chk("pop data", 32'(data_out), 32'(w));
            end
        end
    end

    initial begin
        reset_L = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        af_th   = 2'd3;
        ae_th   = 2'd1;
        #2;
        reset_L = 1'b0;
        #1;
        checkResetOutputs("reset");
        modelReset();
        monOn = 1'b1;

        // Fill to full through the thresholds, then overflow, then drain in order.
        for (int i = 1; i <= 4; i++) doCycle(1, 0, DW'(i));
        doCycle(1, 0, 6'h3F);
        for (int i = 0; i < 4; i++) doCycle(0, 1, '0);
        doCycle(0, 0, '0);

        // Underflow on empty; error must persist through legal traffic.
        doCycle(0, 1, '0);
        doCycle(0, 0, '0);
        doCycle(1, 0, 6'h15);
        doCycle(0, 1, '0);
        doCycle(0, 0, '0);
        asyncReset();

        // Full with simultaneous push/pop for 6 cycles across the pointer wrap.
        for (int i = 0; i < 4; i++) doCycle(1, 0, DW'(6'h10 + i));
        for (int i = 0; i < 6; i++) doCycle(1, 1, DW'(6'h20 + i));
        for (int i = 0; i < 4; i++) doCycle(0, 1, '0);
        doCycle(0, 0, '0);

        // Simultaneous push/pop on empty: push lands, pop underflows.
        doCycle(1, 1, 6'h2A);
        doCycle(0, 1, '0);
        doCycle(0, 0, '0);

        // Async reset with two words held; push in the release cycle must be honoured.
        doCycle(1, 0, 6'h07);
        doCycle(1, 0, 6'h08);
        doCycle(0, 0, '0);
        asyncReset();
        doCycle(1, 0, 6'h33);
        doCycle(0, 1, '0);
        doCycle(0, 0, '0);

        // Randomized traffic with changing thresholds and one reset midway.
        for (int i = 0; i < 400; i++) begin
            if (i % 16 == 0) begin
                af_th = AW'($urandom_range(0, 3));
                ae_th = AW'($urandom_range(0, 3));
            end
            doCycle(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
                    DW'($urandom_range(0, 63)));
            if (i == 200) begin
                doCycle(0, 0, '0);
                asyncReset();
            end
        end
        doCycle(0, 0, '0);
        doCycle(0, 0, '0);
        @(posedge clk);
        #3;
        chk("scoreboard drained", 32'(expQ.size()), 32'd0);
        monOn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
